counter_time_param: RTL and testbench
=====================================

# counter_time_param

Parametrised successor to the team's fixed 3-bit enabled counter: a WIDTH-bit timer/counter with programmable modulus, up/down direction, parallel load, enable prescaler, and auto-reload or one-shot mode. It sits in the datapath timing section, driving event-rate and timeout control. The terminal-count pulse WRAP can cascade into another instance's E.

## Interface
- WIDTH, 8: counter width in bits.
- MAX_COUNT, 2**WIDTH-1: terminal value for up counting and reload value for down counting. Must satisfy 1 ≤ MAX_COUNT ≤ 2**WIDTH-1.
- PRESCALE, 1: number of enabled cycles per count step. Must be ≥ 1; 1 means no prescaling.

- CLK  in  1  sole clock; all state updates on its rising edge.
- CLEAR_N  in  1  asynchronous, active-low reset.
- CLEAR  in  1  synchronous clear, active-high.
- E  in  1  count enable.
- UP  in  1  direction: 1 = up, 0 = down.
- ONESHOT  in  1  mode: 1 = halt at terminal, 0 = auto-reload.
- LOAD  in  1  synchronous parallel load.
- LOAD_VAL  in  WIDTH  load value.
- COUNT  out  WIDTH  current count (registered).
- WRAP  out  1  one-cycle terminal-event pulse (registered).
- DONE  out  1  high while halted in one-shot mode (registered).

## Operation
- **Reset values** (CLEAR_N low): COUNT=0, WRAP=0, DONE=0, prescaler=0, state=CNT_RUN.
- **Priority per edge:** CLEAR > LOAD > step > hold.
- **CLEAR:** same effect as reset.
- **LOAD:**
  - COUNT ← min(LOAD_VAL, MAX_COUNT).
  - Prescaler ← 0, state ← CNT_RUN, DONE ← 0, WRAP ← 0.
- **Tick:** asserted when E=1, state=CNT_RUN, and prescaler == PRESCALE-1.
  - On a tick the prescaler resets to 0.
  - Otherwise, when E=1 in CNT_RUN, the prescaler increments.
  - With E=0, the prescaler holds.
- **Step:** a tick that is not overridden by CLEAR or LOAD.
- **Terminal value:** MAX_COUNT when UP=1; 0 when UP=0.
- **Step, COUNT not at terminal:** COUNT ± 1.
- **Step, COUNT at terminal (terminal event):** WRAP ← 1 for one cycle, then:
  - ONESHOT=0: COUNT ← 0 (up) or MAX_COUNT (down).
  - ONESHOT=1: COUNT holds, state ← CNT_HALT, DONE ← 1.
- **WRAP:** 0 on every edge that is not a terminal event.
- **CNT_HALT:**
  - E is ignored and the prescaler freezes.
  - Exit only via CLEAR, LOAD or reset, back to CNT_RUN.
  - Deasserting ONESHOT does not exit.
- **UP or ONESHOT changes mid-count:** sampled at the next step; prescaler unaffected.
- **Arithmetic:** all math is in WIDTH bits. With MAX_COUNT < 2**WIDTH-1, COUNT never exceeds MAX_COUNT.

## Timing
- Step latency: COUNT shows the new value one edge after the qualifying tick.
- WRAP and DONE rise on the same edge as the terminal-event COUNT update. WRAP is high for exactly one cycle.
- With PRESCALE=P and E held high, COUNT changes every P cycles.
- An up auto-reload period is (MAX_COUNT+1)·P cycles between WRAP pulses.
- Cascade: feeding WRAP into a downstream E gives a single-cycle enable, one cycle late.
- Simultaneous LOAD and terminal step: LOAD wins, WRAP=0.
- CLEAR_N assertion mid-count clears all state immediately, independent of CLK. Deassertion is synchronised externally.

## Structure
- Shared package counter_time_pkg:
  - State encoding constants CNT_RUN=1'b0 and CNT_HALT=1'b1.
  - clog2 function used to size the prescaler (minimum width 1).
- Sub-module counter_prescale, containing the prescaler:
  - Parameter PRESCALE.
  - Ports CLK, CLEAR_N, CLR (CLEAR|LOAD), EN (E & run), TICK.
- The top level holds COUNT, the state register, and the WRAP/DONE registers.

## Test plan
- **Reset mid-count:** WIDTH=8, E=1, after 5 cycles pull CLEAR_N low asynchronously → COUNT=0, WRAP=0, DONE=0 before the next edge; counting resumes from 0 after release.
- **Up auto-reload:** MAX_COUNT=9, PRESCALE=1, UP=1, ONESHOT=0, E=1 → COUNT runs 0..9 then 0; WRAP high for exactly the cycle COUNT returns to 0; period 10 cycles.
- **Down prescaled:** MAX_COUNT=5, PRESCALE=3, UP=0, E=1 → COUNT steps 0→5→4…, one step per 3 cycles. Toggling E low for 2 cycles stretches the interval by 2.
- **One-shot up:** MAX_COUNT=3, ONESHOT=1, UP=1 from COUNT=0 → after 4 steps COUNT stays 3, DONE=1, a single WRAP pulse, and no change with E held for 10 cycles. LOAD_VAL=1 then gives COUNT=1, DONE=0, counting resumes.
- **Load clamp and priority:** MAX_COUNT=9, LOAD_VAL=200 → COUNT=9. LOAD coincident with a terminal step → COUNT=LOAD_VAL, WRAP=0. CLEAR with LOAD=1 → COUNT=0.
- **Direction change:** switch UP=1→0 at COUNT=4 → next step gives 3, prescaler phase preserved.

Source files
------------

// File: rtl/counter_time_pkg.sv
// Shared definitions for the parametrised timer/counter: state encoding and
// a width helper used to size the prescaler register.
package counter_time_pkg;

    localparam logic [0:0] CNT_RUN  = 1'b0;
    localparam logic [0:0] CNT_HALT = 1'b1;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/counter_prescale.sv
// Enable prescaler: emits TICK on every PRESCALE-th enabled cycle.
module counter_prescale
    import counter_time_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic CLEAR_N,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam int              PW   = clog2(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_phase;

    assign TICK = EN && (r_phase == LAST);

    // Phase only advances while enabled, so gaps in EN stretch the interval.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            r_phase <= '0;
        end else if (CLR) begin
            r_phase <= '0;
        end else if (EN) begin
            if (TICK) r_phase <= '0;
            else      r_phase <= r_phase + 1'b1;
        end
    end

endmodule

// File: rtl/counter_time_param.sv
// WIDTH-bit up/down timer with programmable modulus, parallel load, enable
// prescaler and auto-reload / one-shot terminal behaviour.
module counter_time_param
    import counter_time_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int PRESCALE  = 1
) (
    input  logic             CLK,
    input  logic             CLEAR_N,
    input  logic             CLEAR,
    input  logic             E,
    input  logic             UP,
    input  logic             ONESHOT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] COUNT,
    output logic             WRAP,
    output logic             DONE,
    output logic             DBG_STATE
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] r_count;
    logic [0:0]       r_state;
    logic             r_wrap;
    logic             r_done;

    logic             w_en;
    logic             w_clr;
    logic             w_tick;
    logic [WIDTH-1:0] w_term_val;
    logic             w_at_term;
    logic [WIDTH-1:0] w_load_val;

    assign w_en       = E && (r_state == CNT_RUN);
    assign w_clr      = CLEAR || LOAD;
    assign w_term_val = UP ? MAX_V : '0;
    assign w_at_term  = (r_count == w_term_val);
    assign w_load_val = (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;

    counter_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .CLK     (CLK),
        .CLEAR_N (CLEAR_N),
        .CLR     (w_clr),
        .EN      (w_en),
        .TICK    (w_tick)
    );

    // CLEAR beats LOAD beats a step; a halted counter never ticks.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            r_count <= '0;
            r_state <= CNT_RUN;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (CLEAR) begin
            r_count <= '0;
            r_state <= CNT_RUN;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (LOAD) begin
            r_count <= w_load_val;
            r_state <= CNT_RUN;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_tick) begin
                if (w_at_term) begin
                    r_wrap <= 1'b1;
                    if (ONESHOT) begin
                        r_state <= CNT_HALT;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= UP ? '0 : MAX_V;
                    end
                end else begin
                    r_count <= UP ? (r_count + 1'b1) : (r_count - 1'b1);
                end
            end
        end
    end

    assign COUNT     = r_count;
    assign WRAP      = r_wrap;
    assign DONE      = r_done;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_counter_time_param.sv
// Bench for counter_time_param: four differently parametrised instances share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_counter_time_param;

    localparam int NI = 4;
    localparam int WV[NI]   = '{8, 8, 4, 8};
    localparam int MAXV[NI] = '{9, 5, 15, 3};
    localparam int PV[NI]   = '{1, 3, 2, 1};

    logic       clk;
    logic       clear_n;
    logic       clear;
    logic       e;
    logic       up;
    logic       oneshot;
    logic       load;
    logic [7:0] lv;

    logic [7:0] cnt_a, cnt_b, cnt_d;
    logic [3:0] cnt_c;
    logic [NI-1:0] wrap_o, done_o, st_o;

    int m_cnt[NI];
    int m_ph[NI];
    int m_halt[NI];
    int m_wrap[NI];

    int n_vec;
    int n_err;
    int cyc_no;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    counter_time_param #(.WIDTH(8), .MAX_COUNT(9), .PRESCALE(1)) u_a (
        .CLK(clk), .CLEAR_N(clear_n), .CLEAR(clear), .E(e), .UP(up), .ONESHOT(oneshot),
        .LOAD(load), .LOAD_VAL(lv), .COUNT(cnt_a), .WRAP(wrap_o[0]), .DONE(done_o[0]),
        .DBG_STATE(st_o[0]));
    counter_time_param #(.WIDTH(8), .MAX_COUNT(5), .PRESCALE(3)) u_b (
        .CLK(clk), .CLEAR_N(clear_n), .CLEAR(clear), .E(e), .UP(up), .ONESHOT(oneshot),
        .LOAD(load), .LOAD_VAL(lv), .COUNT(cnt_b), .WRAP(wrap_o[1]), .DONE(done_o[1]),
        .DBG_STATE(st_o[1]));
    counter_time_param #(.WIDTH(4), .PRESCALE(2)) u_c (
        .CLK(clk), .CLEAR_N(clear_n), .CLEAR(clear), .E(e), .UP(up), .ONESHOT(oneshot),
        .LOAD(load), .LOAD_VAL(lv[3:0]), .COUNT(cnt_c), .WRAP(wrap_o[2]), .DONE(done_o[2]),
        .DBG_STATE(st_o[2]));
    counter_time_param #(.WIDTH(8), .MAX_COUNT(3), .PRESCALE(1)) u_d (
        .CLK(clk), .CLEAR_N(clear_n), .CLEAR(clear), .E(e), .UP(up), .ONESHOT(oneshot),
        .LOAD(load), .LOAD_VAL(lv), .COUNT(cnt_d), .WRAP(wrap_o[3]), .DONE(done_o[3]),
        .DBG_STATE(st_o[3]));

    function automatic int cnt_of(input int k);
        case (k)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            2:       return int'(cnt_c);
            default: return int'(cnt_d);
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc_no, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_cnt[k] = 0; m_ph[k] = 0; m_halt[k] = 0; m_wrap[k] = 0;
        end
    endtask

    // One rising edge of the ideal counter, from the rules of operation.
    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            int lvk;
            int term;
            lvk = int'(lv) % (1 << WV[k]);
            if (clear) begin
                m_cnt[k] = 0; m_ph[k] = 0; m_halt[k] = 0; m_wrap[k] = 0;
            end else if (load) begin
                m_cnt[k] = (lvk > MAXV[k]) ? MAXV[k] : lvk;
                m_ph[k] = 0; m_halt[k] = 0; m_wrap[k] = 0;
            end else begin
                m_wrap[k] = 0;
                if (!m_halt[k] && e) begin
                    if (m_ph[k] == PV[k] - 1) begin
                        m_ph[k] = 0;
                        term = up ? MAXV[k] : 0;
                        if (m_cnt[k] == term) begin
                            m_wrap[k] = 1;
                            if (oneshot) m_halt[k] = 1;
                            else         m_cnt[k] = up ? 0 : MAXV[k];
                        end else begin
                            m_cnt[k] = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
                        end
                    end else begin
                        m_ph[k] = m_ph[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("count%0d", k), cnt_of(k), m_cnt[k]);
            check($sformatf("wrap%0d", k), int'(wrap_o[k]), m_wrap[k]);
            check($sformatf("done%0d", k), int'(done_o[k]), m_halt[k]);
            check($sformatf("state%0d", k), int'(st_o[k]), m_halt[k]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic c, input logic l, input int v, input logic en,
                          input logic u, input logic os);
        clear = c; load = l; lv = 8'(v); e = en; up = u; oneshot = os;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc_no++;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 clear_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int first_wrap;
        int second_wrap;
        int wraps_d;

        n_vec = 0; n_err = 0; cyc_no = 0;
        model_reset();
        clear_n = 1'b0;
        set_in(0, 0, 0, 0, 1, 0);
        #3;
        check_all();
        @(negedge clk);
        clear_n = 1'b1;

        // reset mid-count, then resume from 0
        set_in(0, 0, 0, 1, 1, 0);
        run(5);
        async_reset();
        run(4);

        // up auto-reload: WRAP period on the MAX_COUNT=9 instance
        set_in(1, 0, 0, 0, 1, 0); cyc();
        set_in(0, 0, 0, 1, 1, 0);
        first_wrap = -1; second_wrap = -1;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (wrap_o[0]) begin
                if (first_wrap < 0) first_wrap = i;
                else if (second_wrap < 0) second_wrap = i;
            end
        end
        check("periodA", second_wrap - first_wrap, 10);
        check("firstwrapA", first_wrap, 10);

        // down, prescaled, with an enable gap
        set_in(1, 0, 0, 0, 0, 0); cyc();
        set_in(0, 0, 0, 1, 0, 0); run(10);
        set_in(0, 0, 0, 0, 0, 0); run(2);
        set_in(0, 0, 0, 1, 0, 0); run(10);

        // one-shot up: single WRAP, halt at 3, then LOAD restarts
        set_in(1, 0, 0, 0, 1, 1); cyc();
        set_in(0, 0, 0, 1, 1, 1);
        wraps_d = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (wrap_o[3]) wraps_d++;
        end
        check("oswrapsD", wraps_d, 1);
        check("oscountD", int'(cnt_d), 3);
        check("osdoneD", int'(done_o[3]), 1);
        set_in(0, 0, 0, 1, 1, 0); run(2);
        set_in(0, 1, 1, 1, 1, 1); cyc();
        check("osloadD", int'(cnt_d), 1);
        check("osloaddoneD", int'(done_o[3]), 0);
        set_in(0, 0, 0, 1, 1, 1); run(3);

        // load clamp and priority
        set_in(0, 1, 200, 0, 1, 0); cyc();
        check("clampA", int'(cnt_a), 9);
        set_in(0, 1, 4, 1, 1, 0); cyc();
        check("ldwinA", int'(cnt_a), 4);
        check("ldwrapA", int'(wrap_o[0]), 0);
        set_in(1, 1, 7, 1, 1, 0); cyc();
        check("clrldA", int'(cnt_a), 0);

        // direction change at COUNT=4
        set_in(0, 0, 0, 1, 1, 0); run(4);
        set_in(0, 0, 0, 1, 0, 0); cyc();
        check("dirA", int'(cnt_a), 3);
        run(6);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
                   int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) async_reset();
            else cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
